cdb_arbiter: RTL and testbench
==============================

// Module: cdb_arbiter
// PURPOSE
//  Sits directly downstream of the functional units: the ALUs and the load/store unit.
//  Each FU writes its completed result (ROB tag, physical dst reg, data) into a
//  small per-source skid FIFO. One result per cycle is granted, round-robin, onto
//  the registered common data bus (CDB), which feeds the reservation stations and the ROB.
// PARAMETERS
//  NUM_SRC     3    number of result producers (ALU0, ALU1, LSU)
//  FIFO_DEPTH  2    entries per source FIFO; power of two, >=2
//  TAG_W       5    ROB tag width (= `ROB_SIZE_WIDTH)
//  PREG_W      7    physical register index width (= `PHYSICAL_REG_NUM_WIDTH)
//  DATA_W      32   result data width
// PORTS
//  clk            in   1                 single clock, rising edge
//  reset          in   1                 asynchronous, active-low
//  flush          in   1                 sync pipeline flush (mispredict/exception from commit)
//  src_valid      in   NUM_SRC           FU result valid, one bit per source
//  src_ready      out  NUM_SRC           source FIFO not full
//  src_tag        in   NUM_SRC*TAG_W     per-source ROB tag, source i at [i*TAG_W +: TAG_W]
//  src_reg_dst    in   NUM_SRC*PREG_W    per-source physical destination register
//  src_data       in   NUM_SRC*DATA_W    per-source result data
//  cdb_valid      out  1                 CDB broadcast valid
//  cdb_tag        out  TAG_W             broadcast ROB tag
//  cdb_reg_dst    out  PREG_W            broadcast physical destination register
//  cdb_data       out  DATA_W            broadcast data
//  cdb_src        out  $clog2(NUM_SRC)   index of the granted source (debug/ROB stats)
// BEHAVIOUR
//  - Reset (reset==0, async): every FIFO is empty; all wr/rd pointers and counts are 0.
//    cdb_valid=0; cdb_tag, cdb_reg_dst, cdb_data and cdb_src are 0. RR pointer=0.
//    src_ready=all 1s. This applies from the first edge after reset deasserts.
//  - Push: source i is written when src_valid[i] && src_ready[i] at posedge.
//    src_ready[i] = (count[i] != FIFO_DEPTH), taken from registered state only.
//    There is no combinational path from the pop to ready.
//  - Full FIFO with a pop in the same cycle: src_ready stays 0. The freed slot is
//    offered on the next cycle. A valid while ready=0 is ignored; the FU must hold it.
//  - Arbitration (combinational on FIFO non-empty flags):
//    - Grant the first non-empty source scanning rr_ptr, rr_ptr+1, ... mod NUM_SRC.
//    - On a grant, pop that FIFO head; rr_ptr <= (grant+1) mod NUM_SRC.
//    - With no requester, rr_ptr holds.
//  - CDB output is registered, and at most one broadcast per cycle:
//    - cdb_* <= granted head, cdb_valid <= 1.
//    - With no grant, cdb_valid <= 0 and the payload holds its old value.
//  - Latency: a result pushed at edge N is broadcast (cdb_valid=1) from edge N+1
//    at the earliest. An uncontended source sustains 1 result/cycle.
//  - Push to an empty FIFO in the same cycle has no bypass. The entry is eligible
//    for grant in the following cycle.
//  - FIFO pointers are log2(FIFO_DEPTH) bits and wrap naturally. count is
//    log2(FIFO_DEPTH)+1 bits.
//  - Simultaneous push and pop on the same FIFO: count unchanged, both pointers advance.
//  - Flush (synchronous, highest priority):
//    - All FIFOs are emptied, and pushes in the flush cycle are discarded.
//    - cdb_valid <= 0; rr_ptr <= 0.
//    - src_ready is all 1s the next cycle.
//  - Reset asserted mid-operation: immediate async clear to the reset state. Any
//    in-flight results are dropped.
// CONFIGURATION
//  CDB_ARB_PERF_EN defined:
//    - Adds output perf_stall_cnt [NUM_SRC*32]: per source, a 32-bit saturating count
//      of cycles with src_valid[i]=1 && src_ready[i]=0.
//    - Adds output perf_bcast_cnt [32]: saturating count of cdb_valid cycles.
//    - Both counters clear on reset only; flush does not clear them.
//  CDB_ARB_PERF_EN undefined:
//    - Neither port exists and no counter logic is built.
//    - All other behaviour is identical.
// TESTING
//  1 Single result: after reset, src0 push tag=3 dst=17 data=0xDEAD -> next cycle
//    cdb_valid=1, tag=3, dst=17, data=0xDEAD, cdb_src=0; following cycle cdb_valid=0.
//  2 Contention: src0,1,2 all push every cycle for 6 cycles -> cdb_src sequence
//    0,1,2,0,1,2 with no gaps; src_ready drops to 0 once a FIFO reaches 2 entries.
//  3 Backpressure: src2 holds valid while others flood -> src2 sees ready=0 at most
//    NUM_SRC-1 cycles per grant; no result lost or duplicated (scoreboard on tags).
//  4 Flush: fill all FIFOs, assert flush one cycle -> next cycle cdb_valid=0,
//    src_ready=3'b111, no stale tag is ever broadcast afterwards.
//  5 Async reset mid-stream: drop reset between edges while cdb_valid=1 -> cdb_valid=0
//    immediately, before the next edge; ready all 1s after release.
//  6 With CDB_ARB_PERF_EN: src1 held stalled for 4 cycles -> perf_stall_cnt[1]=4;
//    perf_bcast_cnt equals the number of cdb_valid cycles observed.

Source files
------------

// File: rtl/cdb_arbiter.sv
// CDB arbiter: per-source skid FIFOs, round-robin grant, registered CDB.
// Ports: clk, reset (async low), flush, src_* in/ready out, cdb_* out, perf_* when CDB_ARB_PERF_EN.
module cdb_arbiter #(
  parameter int NUM_SRC    = 3,
  parameter int FIFO_DEPTH = 2,
  parameter int TAG_W      = 5,
  parameter int PREG_W     = 7,
  parameter int DATA_W     = 32,
  localparam int SRC_W     = $clog2(NUM_SRC)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [NUM_SRC-1:0]        src_valid,
  output logic [NUM_SRC-1:0]        src_ready,
  input  logic [NUM_SRC*TAG_W-1:0]  src_tag,
  input  logic [NUM_SRC*PREG_W-1:0] src_reg_dst,
  input  logic [NUM_SRC*DATA_W-1:0] src_data,
  output logic                      cdb_valid,
  output logic [TAG_W-1:0]          cdb_tag,
  output logic [PREG_W-1:0]         cdb_reg_dst,
  output logic [DATA_W-1:0]         cdb_data,
  output logic [SRC_W-1:0]          cdb_src
`ifdef CDB_ARB_PERF_EN
  ,
  output logic [NUM_SRC*32-1:0]     perf_stall_cnt,
  output logic [31:0]               perf_bcast_cnt
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int ENT_W = TAG_W + PREG_W + DATA_W;

  logic [ENT_W-1:0] r_mem [NUM_SRC][FIFO_DEPTH];
  logic [PTR_W-1:0] r_wr  [NUM_SRC];
  logic [PTR_W-1:0] r_rd  [NUM_SRC];
  logic [CNT_W-1:0] r_cnt [NUM_SRC];
  logic [SRC_W-1:0] r_rr;

  logic              r_cdb_vld;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [PREG_W-1:0] r_cdb_dst;
  logic [DATA_W-1:0] r_cdb_data;
  logic [SRC_W-1:0]  r_cdb_src;

  logic [NUM_SRC-1:0] w_push;
  logic [NUM_SRC-1:0] w_pop;
  logic               w_gnt_vld;
  logic [SRC_W-1:0]   w_gnt;
  logic [SRC_W-1:0]   w_rr_nxt;
  logic [ENT_W-1:0]   w_head;

  // Ready comes from registered counts only; a pop never frees a slot
  // for a push in the same cycle.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      src_ready[i] = (r_cnt[i] != CNT_W'(FIFO_DEPTH));
      w_push[i]    = src_valid[i] & src_ready[i] & ~flush;
    end
  end

  // First non-empty source starting at the round-robin pointer.
  always_comb begin
    int j;
    j         = 0;
    w_gnt_vld = 1'b0;
    w_gnt     = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      j = int'(r_rr) + k;
      if (j >= NUM_SRC) j = j - NUM_SRC;
      if (!w_gnt_vld && r_cnt[j] != '0) begin
        w_gnt_vld = 1'b1;
        w_gnt     = SRC_W'(j);
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      w_pop[i] = w_gnt_vld && (int'(w_gnt) == i);
    w_rr_nxt = (w_gnt == SRC_W'(NUM_SRC - 1)) ? '0 : w_gnt + SRC_W'(1);
    w_head   = r_mem[w_gnt][r_rd[w_gnt]];
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++)
      if (w_push[i])
        r_mem[i][r_wr[i]] <= {src_tag[i*TAG_W +: TAG_W],
                              src_reg_dst[i*PREG_W +: PREG_W],
                              src_data[i*DATA_W +: DATA_W]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_rr       <= '0;
      r_cdb_vld  <= 1'b0;
      r_cdb_tag  <= '0;
      r_cdb_dst  <= '0;
      r_cdb_data <= '0;
      r_cdb_src  <= '0;
    end else if (flush) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        r_wr[i]  <= '0;
        r_rd[i]  <= '0;
        r_cnt[i] <= '0;
      end
      r_rr      <= '0;
      r_cdb_vld <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++) begin
        if (w_push[i]) r_wr[i] <= r_wr[i] + PTR_W'(1);
        if (w_pop[i])  r_rd[i] <= r_rd[i] + PTR_W'(1);
        if (w_push[i] && !w_pop[i])
          r_cnt[i] <= r_cnt[i] + CNT_W'(1);
        else if (!w_push[i] && w_pop[i])
          r_cnt[i] <= r_cnt[i] - CNT_W'(1);
      end
      r_cdb_vld <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rr       <= w_rr_nxt;
        r_cdb_tag  <= w_head[ENT_W-1 -: TAG_W];
        r_cdb_dst  <= w_head[DATA_W +: PREG_W];
        r_cdb_data <= w_head[DATA_W-1:0];
        r_cdb_src  <= w_gnt;
      end
    end
  end

  assign cdb_valid   = r_cdb_vld;
  assign cdb_tag     = r_cdb_tag;
  assign cdb_reg_dst = r_cdb_dst;
  assign cdb_data    = r_cdb_data;
  assign cdb_src     = r_cdb_src;

`ifdef CDB_ARB_PERF_EN
  logic [31:0] r_stall [NUM_SRC];
  logic [31:0] r_bcast;

  // Counters survive flush; only reset clears them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_SRC; i++) r_stall[i] <= '0;
      r_bcast <= '0;
    end else begin
      for (int i = 0; i < NUM_SRC; i++)
        if (src_valid[i] && !src_ready[i] && r_stall[i] != '1)
          r_stall[i] <= r_stall[i] + 32'd1;
      if (r_cdb_vld && r_bcast != '1)
        r_bcast <= r_bcast + 32'd1;
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++)
      perf_stall_cnt[i*32 +: 32] = r_stall[i];
  end
  assign perf_bcast_cnt = r_bcast;
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-based reference model,
// directed scenarios plus randomized traffic with flushes and resets.
module tb_cdb_arbiter;

  typedef struct packed {
    logic [4:0]  tag;
    logic [6:0]  dst;
    logic [31:0] data;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  v = '0;
  ent_t        in_e [3];
  logic [2:0]  src_ready;
  logic [14:0] src_tag;
  logic [20:0] src_reg_dst;
  logic [95:0] src_data;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [6:0]  cdb_reg_dst;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;
`ifdef CDB_ARB_PERF_EN
  logic [95:0] perf_stall_cnt;
  logic [31:0] perf_bcast_cnt;
`endif

  always #5 clk = ~clk;

  assign src_tag     = {in_e[2].tag, in_e[1].tag, in_e[0].tag};
  assign src_reg_dst = {in_e[2].dst, in_e[1].dst, in_e[0].dst};
  assign src_data    = {in_e[2].data, in_e[1].data, in_e[0].data};

  cdb_arbiter dut (
    .clk(clk), .reset(reset), .flush(flush),
    .src_valid(v), .src_ready(src_ready),
    .src_tag(src_tag), .src_reg_dst(src_reg_dst), .src_data(src_data),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_reg_dst(cdb_reg_dst),
    .cdb_data(cdb_data), .cdb_src(cdb_src)
`ifdef CDB_ARB_PERF_EN
    , .perf_stall_cnt(perf_stall_cnt), .perf_bcast_cnt(perf_bcast_cnt)
`endif
  );

  // Reference model state
  ent_t q [3][$];
  int   m_rr;
  bit   m_valid;
  ent_t m_pay;
  int   m_src;
  bit   acc [3];
  int   m_stall [3];
  int   m_bcast;
  int   n_chk = 0;
  int   n_err = 0;
  int   tagc = 0;

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      q[i].delete();
      acc[i] = 0;
      m_stall[i] = 0;
    end
    m_rr = 0; m_valid = 0; m_pay = '0; m_src = 0; m_bcast = 0;
  endtask

  // One clock: model predicts from pre-edge state, then DUT is compared.
  task automatic step();
    bit rdy [3];
    int g;
    g = -1;
    for (int i = 0; i < 3; i++) rdy[i] = q[i].size() < 2;
    for (int k = 0; k < 3; k++)
      if (g < 0 && q[(m_rr + k) % 3].size() > 0) g = (m_rr + k) % 3;
    for (int i = 0; i < 3; i++) begin
      acc[i] = v[i] && rdy[i] && !flush;
      if (v[i] && !rdy[i] && m_stall[i] != 32'hffff_ffff) m_stall[i]++;
    end
    if (m_valid) m_bcast++;
    @(posedge clk);
    if (flush) begin
      for (int i = 0; i < 3; i++) q[i].delete();
      m_rr = 0;
      m_valid = 0;
    end else begin
      if (g >= 0) begin
        m_pay = q[g].pop_front();
        m_src = g;
        m_valid = 1;
        m_rr = (g + 1) % 3;
      end else m_valid = 0;
      for (int i = 0; i < 3; i++) if (acc[i]) q[i].push_back(in_e[i]);
    end
    #1;
    chk("cdb_valid", 64'(cdb_valid), 64'(m_valid));
    chk("cdb_tag", 64'(cdb_tag), 64'(m_pay.tag));
    chk("cdb_reg_dst", 64'(cdb_reg_dst), 64'(m_pay.dst));
    chk("cdb_data", 64'(cdb_data), 64'(m_pay.data));
    chk("cdb_src", 64'(cdb_src), 64'(m_src));
    chk("src_ready", 64'(src_ready),
        64'({q[2].size() < 2, q[1].size() < 2, q[0].size() < 2}));
`ifdef CDB_ARB_PERF_EN
    for (int i = 0; i < 3; i++)
      chk("perf_stall", 64'(perf_stall_cnt[i*32 +: 32]), 64'(m_stall[i]));
    chk("perf_bcast", 64'(perf_bcast_cnt), 64'(m_bcast));
`endif
  endtask

  function automatic ent_t rnd_ent();
    ent_t e;
    tagc++;
    e.tag  = 5'(tagc);
    e.dst  = 7'($urandom);
    e.data = $urandom;
    return e;
  endfunction

  // FU behaviour: hold a refused result, otherwise maybe offer a new one.
  task automatic drive(int pct);
    for (int i = 0; i < 3; i++) begin
      if (v[i] && !acc[i] && !flush) continue;
      v[i] = ($urandom_range(99) < pct);
      if (v[i]) in_e[i] = rnd_ent();
    end
  endtask

  task automatic do_reset();
    #2 reset = 1'b0;
    v = '0; flush = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    int run;
    int maxrun;
    bit got;
    for (int i = 0; i < 3; i++) in_e[i] = '0;
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rst_valid", 64'(cdb_valid), 64'd0);
    chk("rst_ready", 64'(src_ready), 64'h7);
    chk("rst_tag", 64'(cdb_tag), 64'd0);

    // Single result
    v = 3'b001;
    in_e[0] = '{tag: 5'd3, dst: 7'd17, data: 32'hDEAD};
    step();
    chk("t1_lat_valid", 64'(cdb_valid), 64'd0);
    v = '0;
    step();
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag", 64'(cdb_tag), 64'd3);
    chk("t1_dst", 64'(cdb_reg_dst), 64'd17);
    chk("t1_data", 64'(cdb_data), 64'hDEAD);
    chk("t1_src", 64'(cdb_src), 64'd0);
    step();
    chk("t1_idle", 64'(cdb_valid), 64'd0);

    // Contention: all three flood
    do_reset();
    v = 3'b111;
    for (int i = 0; i < 3; i++) in_e[i] = rnd_ent();
    step();
    for (int k = 0; k < 6; k++) begin
      drive(100);
      step();
      chk("t2_valid", 64'(cdb_valid), 64'd1);
      chk("t2_src", 64'(cdb_src), 64'(k % 3));
      if (k == 0) chk("t2_ready", 64'(src_ready), 64'b001);
    end

    // Flush with full FIFOs
    flush = 1'b1;
    drive(100);
    step();
    chk("t4_valid", 64'(cdb_valid), 64'd0);
    chk("t4_ready", 64'(src_ready), 64'h7);
    flush = 1'b0;
    v = '0;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("t4_no_stale", 64'(cdb_valid), 64'd0);
    end

    // Backpressure on src2 while src0/src1 flood
    run = 0; maxrun = 0;
    for (int k = 0; k < 200; k++) begin
      drive(100);
      step();
      if (v[2] && !src_ready[2]) run++;
      else run = 0;
      if (run > maxrun) maxrun = run;
    end
    chk("t3_max_stall_le2", 64'(maxrun <= 2), 64'd1);

    // Randomized traffic with occasional flushes
    for (int k = 0; k < 2000; k++) begin
      flush = ($urandom_range(49) == 0);
      drive($urandom_range(20, 90));
      step();
    end
    flush = 1'b0;

    // Async reset mid-stream
    got = 0;
    for (int k = 0; k < 100 && !got; k++) begin
      drive(80);
      step();
      got = m_valid;
    end
    chk("t5_reached_valid", 64'(got), 64'd1);
    #1 reset = 1'b0;
    #1;
    chk("t5_async_valid", 64'(cdb_valid), 64'd0);
    chk("t5_async_ready", 64'(src_ready), 64'h7);
    chk("t5_async_data", 64'(cdb_data), 64'd0);
    v = '0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5_release_ready", 64'(src_ready), 64'h7);

    // More random traffic after reset
    for (int k = 0; k < 500; k++) begin
      flush = ($urandom_range(99) == 0);
      drive($urandom_range(30, 100));
      step();
    end
    flush = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
